// File: rtl/scalar_fetch_sequencer.sv
// Scalar fetch sequencer: drives PC set/increment, fetches instructions, and hands them to the decoder.
// Optional fetch-ack watchdog with HALT state enabled by defining FETCH_TIMEOUT_EN.
module scalar_fetch_sequencer #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic [PC_W-1:0] pc_value,
    output logic            set_pc,
    output logic [PC_W-1:0] pc_load,
    output logic            inc_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic            instr_valid,
    output logic [31:0]     instr_out,
    input  logic            instr_ready,
    input  logic            ctrl_flow,
    input  logic            endpgm,
    input  logic            branch_valid,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            busy,
    output logic            done,
    output logic            error
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, LOAD, FETCH, ISSUE, BRANCH, DONE, HALT} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, FETCH, ISSUE, BRANCH, DONE} state_t;
`endif

    state_t          state;
    logic [PC_W-1:0] start_pc_q;
    logic            issue_hs;
    logic            br_resolve;
    logic            unused_target_lsbs;

    assign issue_hs           = instr_valid && instr_ready;
    assign br_resolve         = (state == BRANCH) && branch_valid;
    assign unused_target_lsbs = ^branch_target[1:0];

    // PC control must react to handshake/resolution in the same cycle, so it is decoded
    // from the registered state; imem_addr tracks the external counter directly.
    always_comb begin
        set_pc  = 1'b0;
        inc_pc  = 1'b0;
        pc_load = '0;
        if (state == LOAD) begin
            set_pc  = 1'b1;
            pc_load = start_pc_q;
        end else if (br_resolve && branch_taken) begin
            set_pc  = 1'b1;
            pc_load = {branch_target[PC_W-1:2], 2'b00};
        end else if (br_resolve) begin
            inc_pc  = 1'b1;
        end else if (issue_hs && !endpgm && !ctrl_flow) begin
            inc_pc  = 1'b1;
        end
    end

    assign imem_addr = imem_req ? pc_value : '0;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] fetch_cnt;
    logic             fetch_expired;

    assign fetch_expired = (fetch_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Counts consecutive un-acked FETCH cycles; any non-FETCH cycle clears it.
    always_ff @(posedge clock) begin
        if (!reset_n || state != FETCH || imem_ack) begin
            fetch_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

    assign error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_pc_q  <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            error       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        start_pc_q <= start_pc;
                        busy       <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        error      <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state       <= ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        instr_out   <= imem_data;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (fetch_expired) begin
                        state    <= HALT;
                        imem_req <= 1'b0;
                        error    <= 1'b1;
                    end
`endif
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (endpgm) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (ctrl_flow) begin
                            state <= BRANCH;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                BRANCH: begin
                    if (branch_valid) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    instr_out <= '0;
                end
`ifdef FETCH_TIMEOUT_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
